// File: rtl/alu_seq_core_if.sv
// Operand/command bus between the switch front end and the ALU core.
// The master side drives operands and commands; the slave side (the core)
// returns register contents, result and status.
interface alu_seq_core_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   data_in;
    logic               load_a;
    logic               load_b;
    logic               start;
    logic [3:0]         select;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] result;
    logic               busy;
    logic               done;
    logic               zero;
    logic               carry;
    logic               overflow;
    logic               div_zero;

    modport master (
        output data_in, load_a, load_b, start, select,
        input  a_q, b_q, result, busy, done, zero, carry, overflow, div_zero
    );

    modport slave (
        input  data_in, load_a, load_b, start, select,
        output a_q, b_q, result, busy, done, zero, carry, overflow, div_zero
    );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU: single-cycle logic/arith ops plus multi-cycle
// shift-add multiply and restoring divide with busy/done handshake.
//
// state | meaning
// IDLE  | accepts loads and start; single-cycle ops finish here
// MUL   | one shift-add step per cycle, WIDTH steps
// DIV   | one restoring-subtract step per cycle, WIDTH steps
// FIN   | done pulse, back to IDLE
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_seq_core_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   acc, wq, opb;
    logic [CW-1:0]      cnt;
    logic               is_mod;
    logic [2*WIDTH-1:0] res_r;
    logic               busy_r, done_r, zero_r, carry_r, ovf_r, dz_r;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH:0]     ext;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, div_quo;
    logic [2*WIDTH-1:0] div_res;

    // Single-cycle operations on the current A/B registers.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        ext     = '0;
        case (bus.select)
            4'd0: begin
                ext     = {1'b0, a_r} + {1'b0, b_r};
                alu_res = ext[MSB:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_r[MSB] == b_r[MSB]) && (ext[MSB] != a_r[MSB]);
            end
            4'd1: begin
                ext     = {1'b0, a_r} - {1'b0, b_r};
                alu_res = ext[MSB:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_r[MSB] != b_r[MSB]) && (ext[MSB] != a_r[MSB]);
            end
            4'd2:  alu_res = a_r & b_r;
            4'd3:  alu_res = a_r | b_r;
            4'd4:  alu_res = a_r ^ b_r;
            4'd5:  alu_res = ~a_r;
            4'd6: begin
                alu_res = {a_r[MSB-1:0], 1'b0};
                alu_c   = a_r[MSB];
            end
            4'd7: begin
                alu_res = {1'b0, a_r[MSB:1]};
                alu_c   = a_r[0];
            end
            4'd8: begin
                alu_res = {a_r[MSB], a_r[MSB:1]};
                alu_c   = a_r[0];
            end
            4'd9:  alu_res = {a_r[MSB-1:0], a_r[MSB]};
            4'd10: alu_res = WIDTH'($signed(a_r) < $signed(b_r));
            4'd14: begin
                ext     = {1'b0, a_r} + 1'b1;
                alu_res = ext[MSB:0];
                alu_c   = ext[WIDTH];
                alu_v   = !a_r[MSB] && ext[MSB];
            end
            4'd15: alu_res = b_r;
            default: ;
        endcase
    end

    // One multiply step and one divide step from the working registers.
    always_comb begin
        mul_sum  = {1'b0, acc} + (wq[0] ? {1'b0, opb} : '0);
        mul_prod = {mul_sum[WIDTH:1], mul_sum[0], wq[MSB:1]};
        div_sh   = {acc, wq[MSB]};
        div_ge   = div_sh >= {1'b0, opb};
        // When subtracting, the true difference is below opb so the low bits suffice.
        div_rem  = div_ge ? (div_sh[MSB:0] - opb) : div_sh[MSB:0];
        div_quo  = {wq[MSB-1:0], div_ge};
        div_res  = is_mod ? {{WIDTH{1'b0}}, div_rem} : {div_rem, div_quo};
    end

    // Sequencer, operand registers and registered result/flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            wq      <= '0;
            opb     <= '0;
            cnt     <= '0;
            is_mod  <= 1'b0;
            res_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load_a) a_r <= bus.data_in;
                    if (bus.load_b) b_r <= bus.data_in;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        opb    <= b_r;
                        acc    <= '0;
                        wq     <= a_r;
                        cnt    <= CW'(WIDTH - 1);
                        is_mod <= (bus.select == 4'd13);
                        if (bus.select == 4'd11) begin
                            state <= S_MUL;
                        end else if (bus.select == 4'd12 || bus.select == 4'd13) begin
                            state <= S_DIV;
                        end else begin
                            state   <= S_FIN;
                            done_r  <= 1'b1;
                            res_r   <= {{WIDTH{1'b0}}, alu_res};
                            zero_r  <= (alu_res == '0);
                            carry_r <= alu_c;
                            ovf_r   <= alu_v;
                            dz_r    <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    wq  <= {mul_sum[0], wq[MSB:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state   <= S_FIN;
                        done_r  <= 1'b1;
                        res_r   <= mul_prod;
                        zero_r  <= (mul_prod == '0);
                        carry_r <= 1'b0;
                        ovf_r   <= (mul_sum[WIDTH:1] != '0);
                        dz_r    <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc <= div_rem;
                    wq  <= div_quo;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state   <= S_FIN;
                        done_r  <= 1'b1;
                        res_r   <= div_res;
                        zero_r  <= (div_res == '0);
                        carry_r <= 1'b0;
                        ovf_r   <= 1'b0;
                        dz_r    <= (opb == '0);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_q      = a_r;
    assign bus.b_q      = b_r;
    assign bus.result   = res_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.zero     = zero_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = ovf_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8 with hand-computed expectations.
module tb_alu_seq_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    alu_seq_core_if #(.WIDTH(W)) bus ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        bus.data_in = a;
        bus.load_a  = 1'b1;
        tick();
        bus.load_a  = 1'b0;
        bus.data_in = b;
        bus.load_b  = 1'b1;
        tick();
        bus.load_b  = 1'b0;
    endtask

    // Pulse start; return cycles until done (1 = cycle after start) and busy cycles seen.
    task automatic run(input logic [3:0] op, output int lat, output int bcnt);
        bus.select = op;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
            tick();
        end
    endtask

    task automatic vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [15:0] r, input logic c,
                       input logic v, input logic z, input logic dz, input int elat);
        int lat, bcnt;
        load(a, b);
        run(op, lat, bcnt);
        chk({tag, ".result"}, 32'(bus.result), 32'(r));
        chk({tag, ".flags"}, {28'd0, bus.zero, bus.carry, bus.overflow, bus.div_zero},
            {28'd0, z, c, v, dz});
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".busy_cycles"}, bcnt, elat);
        tick();
        chk({tag, ".done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int lat;
        bit saw_done;
        bus.data_in = '0;
        bus.load_a  = 1'b0;
        bus.load_b  = 1'b0;
        bus.start   = 1'b0;
        bus.select  = '0;

        #12;
        chk("reset.regs", {bus.a_q, bus.b_q, bus.result}, 32'd0);
        chk("reset.flags", {26'd0, bus.busy, bus.done, bus.zero, bus.carry, bus.overflow, bus.div_zero}, 32'd0);
        reset_n = 1'b1;
        tick();

        load(8'hC8, 8'h64);
        chk("load.a_q", 32'(bus.a_q), 32'hC8);
        chk("load.b_q", 32'(bus.b_q), 32'h64);

        //   tag     A      B     op     result    c     v     z     dz  lat
        vec("add",  8'hC8, 8'h64, 4'd0,  16'h002C, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        vec("sub1", 8'h05, 8'h07, 4'd1,  16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        vec("sub2", 8'h7F, 8'h81, 4'd1,  16'h00FE, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        vec("and",  8'h96, 8'h3C, 4'd2,  16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("or",   8'h96, 8'h3C, 4'd3,  16'h00BE, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("xor",  8'h96, 8'h3C, 4'd4,  16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("not",  8'h96, 8'h3C, 4'd5,  16'h0069, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("shl",  8'h96, 8'h3C, 4'd6,  16'h002C, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        vec("shr",  8'h96, 8'h3C, 4'd7,  16'h004B, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("asr",  8'h96, 8'h3C, 4'd8,  16'h00CB, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("rol",  8'h96, 8'h3C, 4'd9,  16'h002D, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("slt1", 8'h96, 8'h3C, 4'd10, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("slt0", 8'h05, 8'h96, 4'd10, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        vec("inc1", 8'h96, 8'h3C, 4'd14, 16'h0097, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("inc2", 8'hFF, 8'h3C, 4'd14, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        vec("inc3", 8'h7F, 8'h3C, 4'd14, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vec("pass", 8'h96, 8'h3C, 4'd15, 16'h003C, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vec("mul1", 8'hFF, 8'hFF, 4'd11, 16'hFE01, 1'b0, 1'b1, 1'b0, 1'b0, 9);
        vec("mul2", 8'h0D, 8'h0B, 4'd11, 16'h008F, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        vec("div1", 8'h64, 8'h07, 4'd12, 16'h020E, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        vec("mod1", 8'h64, 8'h07, 4'd13, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        vec("div0", 8'h2A, 8'h00, 4'd12, 16'h2AFF, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        vec("mod0", 8'h2A, 8'h00, 4'd13, 16'h002A, 1'b0, 1'b0, 1'b0, 1'b1, 9);

        // start + load_a pulsed mid-multiply must be ignored
        load(8'hFF, 8'hFF);
        bus.select = 4'd11;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        bus.data_in = 8'h12;
        bus.load_a  = 1'b1;
        bus.select  = 4'd0;
        bus.start   = 1'b1;
        tick();
        bus.load_a  = 1'b0;
        bus.start   = 1'b0;
        lat = 4;
        while (lat < 40 && !bus.done) begin
            tick();
            lat++;
        end
        chk("midop.latency", lat, 9);
        chk("midop.a_q", 32'(bus.a_q), 32'hFF);
        chk("midop.result", 32'(bus.result), 32'hFE01);
        tick();
        tick();
        chk("midop.no_restart", {30'd0, bus.busy, bus.done}, 32'd0);

        // reset in the middle of a multiply aborts it
        load(8'hFF, 8'hFF);
        bus.select = 4'd11;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort.regs", {bus.a_q, bus.b_q, bus.result}, 32'd0);
        chk("abort.flags", {26'd0, bus.busy, bus.done, bus.zero, bus.carry, bus.overflow, bus.div_zero}, 32'd0);
        tick();
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort.no_done", 32'(saw_done), 32'd0);
        vec("zero", 8'h00, 8'h00, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // load_a in the same cycle as start: op sees the old A/B, a_q updates next cycle
        load(8'h01, 8'h33);
        bus.data_in = 8'h10;
        bus.load_a  = 1'b1;
        bus.select  = 4'd15;
        bus.start   = 1'b1;
        tick();
        bus.load_a  = 1'b0;
        bus.start   = 1'b0;
        chk("same.done", 32'(bus.done), 32'd1);
        chk("same.result", 32'(bus.result), 32'h0033);
        chk("same.a_q", 32'(bus.a_q), 32'h10);
        chk("same.b_q", 32'(bus.b_q), 32'h33);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
